req_slave_pe: RTL and testbench

REQ_SLAVE_PE -- requirements
Module: req_slave_pe

---
 rtl/req_slave_pe_pkg.sv | 14 +
 rtl/req_slave_pe_resp_pipe.sv | 21 ++
 rtl/req_slave_pe.sv | 79 +++++++
 tb/tb_req_slave_pe.sv | 128 ++++++++++++
 4 files changed

// File: rtl/req_slave_pe_pkg.sv
// req_slave_pe_pkg: shared interconnect response encodings and response-entry type
package req_slave_pe_pkg;
  localparam logic OPC_OK = 1'b0;
  localparam logic OPC_ERR = 1'b1;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;
  localparam int RESP_DATA_MAX = 64;
  localparam int RESP_ID_MAX = 16;
  typedef struct packed {
    logic valid;
    logic opc;
    logic [RESP_ID_MAX-1:0] id;
    logic [RESP_DATA_MAX-1:0] rdata;
  } resp_t;
endpackage

// File: rtl/req_slave_pe_resp_pipe.sv
// resp_pipe_pe: fixed-depth response delay line with synchronous clear
module resp_pipe_pe #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) s[i] <= '0;
    end else begin
      s[0] <= d;
      for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
    end
  end
  assign q = s[DEPTH-1];
endmodule

// File: rtl/req_slave_pe.sv
// req_slave_pe: word-register slave with write counter and fixed-latency responses
module req_slave_pe
  import req_slave_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 5,
  parameter int N_REGS = 8,
  parameter int RESP_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_add_i,
  input  logic                    data_wen_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ID_WIDTH-1:0]     data_ID_i,
  output logic                    data_gnt_o,
  output logic                    data_r_valid_o,
  output logic [DATA_WIDTH-1:0]   data_r_rdata_o,
  output logic                    data_r_opc_o,
  output logic [ID_WIDTH-1:0]     data_r_ID_o
);
  localparam int IW = $clog2(N_REGS);
  localparam int NB = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] regs [N_REGS-1];
  logic [DATA_WIDTH-1:0] cnt, rd;
  logic [IW-1:0] idx;
  logic acc, err, wr;
  resp_t d, q;
  logic unused_bits;
  assign data_gnt_o = data_req_i;
  assign idx = data_add_i[2 +: IW];
  assign acc = data_req_i & ~rst;
  assign err = (data_add_i[1:0] != 2'b00) || (int'(idx) >= N_REGS) ||
               (!data_wen_i && int'(idx) == N_REGS - 1);
  assign wr = acc & ~data_wen_i & ~err;
  // the top index falls through to the counter; out-of-range indices are errors anyway
  always_comb begin
    rd = cnt;
    for (int i = 0; i < N_REGS - 1; i++) rd = (int'(idx) == i) ? regs[i] : rd;
  end
  always_comb begin
    d = '0;
    if (acc) begin
      d.valid = 1'b1;
      d.opc = err ? OPC_ERR : OPC_OK;
      d.id = RESP_ID_MAX'(data_ID_i);
      d.rdata = RESP_DATA_MAX'(err ? ERR_DATA : (data_wen_i ? rd : '0));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REGS - 1; i++) regs[i] <= '0;
      cnt <= '0;
    end else if (wr) begin
      for (int i = 0; i < N_REGS - 1; i++)
        for (int b = 0; b < NB; b++)
          if (int'(idx) == i && data_be_i[b]) regs[i][8*b +: 8] <= data_wdata_i[8*b +: 8];
      cnt <= cnt + DATA_WIDTH'(1);
    end
  end
  resp_pipe_pe #(
    .DEPTH(RESP_LATENCY),
    .W($bits(resp_t))
  ) u_pipe (
    .clk(clk),
    .rst(rst),
    .d(d),
    .q(q)
  );
  assign data_r_valid_o = q.valid;
  assign data_r_rdata_o = q.rdata[DATA_WIDTH-1:0];
  assign data_r_opc_o = q.opc;
  assign data_r_ID_o = q.id[ID_WIDTH-1:0];
  assign unused_bits = ^{q, data_add_i};
endmodule

// File: tb/tb_req_slave_pe.sv
// tb_req_slave_pe: directed table-driven check of req_slave_pe (N_REGS=6, latency 2)
module tb_req_slave_pe;
  localparam int L = 2;
  localparam logic [31:0] BAD = 32'hBADACCE5;
  logic clk = 0, rst = 1;
  logic data_req_i = 0, data_wen_i = 1;
  logic [31:0] data_add_i = 0, data_wdata_i = 0;
  logic [3:0] data_be_i = 0;
  logic [4:0] data_ID_i = 0;
  logic data_gnt_o, data_r_valid_o, data_r_opc_o;
  logic [31:0] data_r_rdata_o;
  logic [4:0] data_r_ID_o;
  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic [4:0] id;
    logic [31:0] erd; logic eopc;
  } vec_t;
  typedef struct { int due; logic [31:0] rd; logic opc; logic [4:0] id; } exp_t;
  exp_t eq[$];
  vec_t tbl [23];

  req_slave_pe #(.N_REGS(6), .RESP_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .data_req_i(data_req_i), .data_add_i(data_add_i),
    .data_wen_i(data_wen_i), .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
    .data_ID_i(data_ID_i), .data_gnt_o(data_gnt_o), .data_r_valid_o(data_r_valid_o),
    .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o), .data_r_ID_o(data_r_ID_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    total++;
    if (data_gnt_o !== data_req_i) begin
      bad++;
      $display("FAIL gnt cyc=%0d got=%b want=%b", cyc, data_gnt_o, data_req_i);
    end
    total++;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      if (data_r_valid_o !== 1'b1 || data_r_rdata_o !== eq[0].rd ||
          data_r_opc_o !== eq[0].opc || data_r_ID_o !== eq[0].id) begin
        bad++;
        $display("FAIL resp cyc=%0d got v=%b rd=%h opc=%b id=%0d want v=1 rd=%h opc=%b id=%0d",
                 cyc, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_ID_o,
                 eq[0].rd, eq[0].opc, eq[0].id);
      end
      void'(eq.pop_front());
    end else if ({data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_ID_o} !== '0) begin
      bad++;
      $display("FAIL idle cyc=%0d got v=%b rd=%h opc=%b id=%0d want all 0",
               cyc, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_ID_o);
    end
  end

  task automatic issue(input vec_t v);
    data_req_i = 1; data_wen_i = v.wen; data_add_i = v.addr;
    data_wdata_i = v.wdata; data_be_i = v.be; data_ID_i = v.id;
    eq.push_back('{due: cyc + L, rd: v.erd, opc: v.eopc, id: v.id});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    data_req_i = 0; data_wen_i = 1; data_add_i = 0; data_wdata_i = 0; data_be_i = 0; data_ID_i = 0;
  endtask

  task automatic drain();
    idle();
    repeat (L + 3) @(posedge clk);
    #1;
    total++;
    if (eq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", eq.size());
      eq.delete();
    end
  endtask

  initial begin
    tbl = '{
      '{1'b0, 32'h08, 32'h11223344, 4'b0101, 5'd1, 32'h0, 1'b0},
      '{1'b1, 32'h08, 32'h0, 4'h0, 5'd2, 32'h00220044, 1'b0},
      '{1'b0, 32'h04, 32'hAAAA5555, 4'hF, 5'd3, 32'h0, 1'b0},
      '{1'b1, 32'h04, 32'h0, 4'h0, 5'd4, 32'hAAAA5555, 1'b0},
      '{1'b1, 32'h04, 32'h0, 4'h0, 5'd5, 32'hAAAA5555, 1'b0},
      '{1'b0, 32'h04, 32'h0, 4'hF, 5'd6, 32'h0, 1'b0},
      '{1'b1, 32'h04, 32'h0, 4'h0, 5'd7, 32'h0, 1'b0},
      '{1'b1, 32'h14, 32'h0, 4'h0, 5'd8, 32'd3, 1'b0},
      '{1'b0, 32'h14, 32'hFFFFFFFF, 4'hF, 5'd9, BAD, 1'b1},
      '{1'b1, 32'h14, 32'h0, 4'h0, 5'd10, 32'd3, 1'b0},
      '{1'b1, 32'h02, 32'h0, 4'h0, 5'd11, BAD, 1'b1},
      '{1'b1, 32'h18, 32'h0, 4'h0, 5'd12, BAD, 1'b1},
      '{1'b1, 32'h1C, 32'h0, 4'h0, 5'd13, BAD, 1'b1},
      '{1'b0, 32'h18, 32'h1, 4'hF, 5'd14, BAD, 1'b1},
      '{1'b0, 32'h09, 32'h12345678, 4'hF, 5'd15, BAD, 1'b1},
      '{1'b1, 32'h08, 32'h0, 4'h0, 5'd16, 32'h00220044, 1'b0},
      '{1'b1, 32'hFFFFFF08, 32'h0, 4'h0, 5'd17, 32'h00220044, 1'b0},
      '{1'b0, 32'h00, 32'hDEADBEEF, 4'b1000, 5'd18, 32'h0, 1'b0},
      '{1'b1, 32'h00, 32'h0, 4'h0, 5'd19, 32'hDE000000, 1'b0},
      '{1'b1, 32'h14, 32'h0, 4'h0, 5'd20, 32'd4, 1'b0},
      '{1'b0, 32'h0C, 32'hFFFFFFFF, 4'h0, 5'd21, 32'h0, 1'b0},
      '{1'b1, 32'h0C, 32'h0, 4'h0, 5'd22, 32'h0, 1'b0},
      '{1'b1, 32'h14, 32'h0, 4'h0, 5'd23, 32'd5, 1'b0}
    };
    // a write presented during reset must be ignored
    data_req_i = 1; data_wen_i = 0; data_add_i = 32'h10; data_wdata_i = 32'hFFFFFFFF; data_be_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    idle();
    rst = 0;
    issue('{1'b1, 32'h10, 32'h0, 4'h0, 5'd30, 32'h0, 1'b0});
    for (int i = 0; i < 23; i++) issue(tbl[i]);
    for (int i = 1; i <= 4; i++) issue('{1'b1, 32'h08, 32'h0, 4'h0, 5'(i), 32'h00220044, 1'b0});
    drain();
    // read accepted, then reset next cycle drops it
    data_req_i = 1; data_wen_i = 1; data_add_i = 32'h08; data_ID_i = 5'd25;
    @(posedge clk); #1;
    data_add_i = 32'h00; data_wen_i = 0; data_wdata_i = 32'h55555555; data_be_i = 4'hF;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 6; i++) issue('{1'b1, 32'(4 * i), 32'h0, 4'h0, 5'(26 + i), 32'h0, 1'b0});
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
